// File: rtl/fll_controller.sv
// Frequency-locked-loop trim controller: counts clock cycles per osc period and steps a thermometer trim word.
// Build with DLL_LOCK_EN defined to include lock detection; otherwise `locked` is tied low.
module fll_controller #(
    parameter int TRIM_BITS   = 26,
    parameter int DIV_BITS    = 8,
    parameter int TRIM_INIT   = 13,
    parameter int HYST        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           osc,
    input  logic [DIV_BITS-1:0]            div,
    input  logic                           dco,
    input  logic [TRIM_BITS-1:0]           ext_trim,
    output logic [TRIM_BITS-1:0]           trim,
    output logic [$clog2(TRIM_BITS+1)-1:0] tval,
    output logic                           locked
);
    // state   | meaning
    // IDLE    | dco bypass, trim follows ext_trim
    // ACQUIRE | first osc edge only primes the period counter
    // TRACK   | one trim adjustment per osc period
    // LOCKED  | LOCK_COUNT consecutive in-window periods seen
    localparam int TW = $clog2(TRIM_BITS + 1);
    localparam int CW = DIV_BITS + 1;

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   osc_edge;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          div_ext;
    logic [CW-1:0]          lo;
    logic [CW-1:0]          hi;
    logic                   up;
    logic                   dn;
    logic [TW-1:0]          tval_adj;
`ifdef DLL_LOCK_EN
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    logic [LCW-1:0]         lock_cnt;
`else
    assign locked = 1'b0;
`endif

    function automatic logic [TRIM_BITS-1:0] thermo(input logic [TW-1:0] v);
        logic [TRIM_BITS-1:0] t;
        for (int i = 0; i < TRIM_BITS; i++) t[i] = (TW'(i) < v);
        return t;
    endfunction

    // cnt holds the period measurement during the osc_edge cycle
    always_comb begin
        div_ext = {1'b0, div};
        if (div == '0) begin
            lo = CW'(HYST);
            hi = CW'(HYST);
        end else begin
            hi = div_ext + CW'(HYST);
            lo = (div_ext > CW'(HYST)) ? div_ext - CW'(HYST) : '0;
        end
        up = (cnt > hi);
        dn = (cnt < lo);
        tval_adj = tval;
        if (up && tval != TW'(TRIM_BITS))
            tval_adj = tval + 1'b1;
        else if (dn && tval != '0)
            tval_adj = tval - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            edge_q   <= 1'b0;
            osc_edge <= 1'b0;
            cnt      <= '0;
            tval     <= TW'(TRIM_INIT);
            trim     <= thermo(TW'(TRIM_INIT));
            state    <= dco ? IDLE : ACQUIRE;
`ifdef DLL_LOCK_EN
            lock_cnt <= '0;
            locked   <= 1'b0;
`endif
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], osc};
            edge_q   <= sync_q[SYNC_STAGES-1];
            osc_edge <= sync_q[SYNC_STAGES-1] & ~edge_q;
            if (osc_edge)
                cnt <= CW'(1);
            else if (cnt != '1)
                cnt <= cnt + 1'b1;

            if (dco) begin
                state <= IDLE;
                trim  <= ext_trim;
`ifdef DLL_LOCK_EN
                lock_cnt <= '0;
                locked   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                        trim  <= thermo(tval);
                    end
                    ACQUIRE: if (osc_edge) state <= TRACK;
                    default: if (osc_edge) begin
                        tval <= tval_adj;
                        trim <= thermo(tval_adj);
`ifdef DLL_LOCK_EN
                        if (up || dn) begin
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= TRACK;
                        end else if (state == TRACK) begin
                            if (lock_cnt == LCW'(LOCK_COUNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                lock_cnt <= lock_cnt + 1'b1;
                            end
                        end
`endif
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fll_controller.sv
// Self-checking bench for fll_controller: directed scenarios plus random periods/div/dco/reset against a cycle model.
module tb_fll_controller;
    localparam int TRIM_BITS   = 26;
    localparam int DIV_BITS    = 8;
    localparam int TRIM_INIT   = 13;
    localparam int HYST        = 1;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_COUNT  = 4;
    localparam int TW          = $clog2(TRIM_BITS + 1);
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int CNT_MAX     = (1 << (DIV_BITS + 1)) - 1;
`ifdef DLL_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 osc = 1'b0;
    logic                 dco = 1'b0;
    logic [DIV_BITS-1:0]  div = 8'd16;
    logic [TRIM_BITS-1:0] ext_trim = '0;
    logic [TRIM_BITS-1:0] trim;
    logic [TW-1:0]        tval;
    logic                 locked;

    int n_cmp = 0;
    int n_bad = 0;

    int  m_tval, m_lcnt, gap, pend, pend_m;
    bit  m_locked, m_primed, m_idle;
    logic [TRIM_BITS-1:0] m_ext;

    always #5 clock = ~clock;

    fll_controller #(
        .TRIM_BITS(TRIM_BITS), .DIV_BITS(DIV_BITS), .TRIM_INIT(TRIM_INIT),
        .HYST(HYST), .SYNC_STAGES(SYNC_STAGES), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clock(clock), .reset(reset), .osc(osc), .div(div), .dco(dco),
        .ext_trim(ext_trim), .trim(trim), .tval(tval), .locked(locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] therm(input int t);
        return (32'h1 << t) - 32'h1;
    endfunction

    task automatic model_reset();
        m_tval = TRIM_INIT; m_locked = 0; m_lcnt = 0; m_primed = 0; m_idle = 0; pend = 0;
    endtask

    // One measured osc period of m clock cycles, judged against the window around div.
    task automatic model_edge(input int m);
        int d, lo, hi;
        d = int'(div);
        if (!m_primed) begin
            m_primed = 1;
            return;
        end
        if (d == 0) begin lo = HYST; hi = HYST; end
        else begin lo = (d > HYST) ? d - HYST : 0; hi = d + HYST; end
        if (m > hi) begin if (m_tval < TRIM_BITS) m_tval++; end
        else if (m < lo) begin if (m_tval > 0) m_tval--; end
        if (LOCK_ON) begin
            if (m > hi || m < lo) begin m_locked = 0; m_lcnt = 0; end
            else if (!m_locked) begin
                m_lcnt++;
                if (m_lcnt >= LOCK_COUNT) m_locked = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
        gap++;
        if (reset) model_reset();
        else if (dco) begin
            m_idle = 1; m_ext = ext_trim; m_locked = 0; m_lcnt = 0; m_primed = 0; pend = 0;
        end else begin
            m_idle = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) model_edge(pend_m);
            end
        end
        check("tval", 32'(tval), 32'(m_tval));
        check("trim", 32'(trim), m_idle ? 32'(m_ext) : therm(m_tval));
        check("locked", 32'(locked), 32'(m_locked));
    endtask

    task automatic rise();
        osc = 1'b1;
        pend_m = (gap > CNT_MAX) ? CNT_MAX : gap;
        gap = 0;
        pend = LAT;
    endtask

    task automatic run_period(input int p);
        rise();
        repeat (p / 2) tick();
        osc = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
    endtask

    initial begin
        model_reset();
        gap = 0;
        m_ext = '0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_tval", 32'(tval), 32'd13);
        check("rst_trim", 32'(trim), 32'h0001FFF);
        check("rst_locked", 32'(locked), 32'd0);
        reset = 1'b0;
        repeat (5) tick();

        div = 8'd16;
        repeat (16) run_period(20);
        check("sat_hi_tval", 32'(tval), 32'd26);
        check("sat_hi_trim", 32'(trim), 32'h3FFFFFF);
        repeat (30) run_period(10);
        check("sat_lo_tval", 32'(tval), 32'd0);
        check("sat_lo_trim", 32'(trim), 32'd0);

        pulse_reset();
        repeat (5) run_period(16);
        check("lock_set", 32'(locked), 32'(LOCK_ON));
        check("lock_tval", 32'(tval), 32'd13);
        repeat (2) run_period(19);
        check("unlock", 32'(locked), 32'd0);
        check("unlock_tval", 32'(tval), 32'd14);

        pulse_reset();
        repeat (21) run_period(17);
        check("hyst_tval", 32'(tval), 32'd13);

        dco = 1'b1; ext_trim = 26'h2AAAAAA;
        tick();
        check("dco_trim", 32'(trim), 32'h2AAAAAA);
        check("dco_locked", 32'(locked), 32'd0);
        repeat (2) run_period(30);
        dco = 1'b0;
        tick();
        check("dco_exit_trim", 32'(trim), 32'h0001FFF);
        repeat (3) run_period(30);
        check("dco_prime_tval", 32'(tval), 32'd15);

        pulse_reset();
        repeat (7) run_period(20);
        repeat (5) run_period(16);
        check("pre_rst_tval", 32'(tval), 32'd20);
        check("pre_rst_locked", 32'(locked), 32'(LOCK_ON));
        reset = 1'b1; tick();
        check("rst_lk_tval", 32'(tval), 32'd13);
        check("rst_lk_trim", 32'(trim), 32'h0001FFF);
        check("rst_lk_locked", 32'(locked), 32'd0);
        reset = 1'b0; tick();

        repeat (3) run_period(16);
        repeat (600) tick();
        run_period(16);
        check("stuck_tval", 32'(tval), 32'd14);

        div = 8'd0;
        repeat (3) run_period(12);

        for (int it = 0; it < 80; it++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                pulse_reset();
            end else if (sel < 3) begin
                dco = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    ext_trim = TRIM_BITS'($urandom());
                    tick();
                end
                dco = 1'b0;
                tick();
            end else begin
                if (sel < 7) div = DIV_BITS'($urandom_range(0, 40));
                repeat (int'($urandom_range(1, 6))) run_period(int'($urandom_range(10, 50)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
